// File: rtl/out_ser.sv
// Parallel-to-serial output stage feeding the IOB output register (ser_sel = bypass select).
// Optional even-parity bit per word when OUT_SER_PARITY_EN is defined.
module out_ser #(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] par_data,
    input  logic             par_valid,
    output logic             par_ready,
    output logic             ser_data,
    output logic             ser_sel,
    output logic             ser_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifndef OUT_SER_PARITY_EN
    localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
`ifdef OUT_SER_PARITY_EN
        ,
        PARITY = 2'd2
`endif
    } state_t;

    // Next bit to present sits at the head of the register.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
    endfunction

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             accept, load, adv;
`ifdef OUT_SER_PARITY_EN
    logic             par_bit;
    logic             to_par;
`endif

    assign accept = par_valid && par_ready;

    always_comb begin
        par_ready = 1'b0;
        case (state)
            IDLE:    par_ready = rst_n;
`ifdef OUT_SER_PARITY_EN
            SHIFT:   par_ready = 1'b0;
            PARITY:  par_ready = rst_n;
`else
            SHIFT:   par_ready = rst_n && (cnt == LAST);
`endif
            default: par_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        adv       = 1'b0;
`ifdef OUT_SER_PARITY_EN
        to_par    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt != LAST) begin
                    adv = 1'b1;
                end else begin
`ifdef OUT_SER_PARITY_EN
                    to_par    = 1'b1;
                    state_nxt = PARITY;
`else
                    // Last data bit doubles as the accept slot for gapless streaming.
                    if (accept) load = 1'b1;
                    else        state_nxt = IDLE;
`endif
                end
            end
`ifdef OUT_SER_PARITY_EN
            PARITY: begin
                if (accept) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            cnt      <= '0;
            ser_data <= IDLE_LEVEL;
            ser_sel  <= 1'b0;
            ser_done <= 1'b0;
            busy     <= 1'b0;
`ifdef OUT_SER_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            ser_done <= 1'b0;
            busy     <= (state_nxt != IDLE);
            if (load) begin
                sr       <= shift1(par_data);
                cnt      <= '0;
                ser_data <= head(par_data);
                ser_sel  <= 1'b1;
`ifdef OUT_SER_PARITY_EN
                par_bit  <= ^par_data;
`endif
            end else if (adv) begin
                sr       <= shift1(sr);
                cnt      <= cnt + CW'(1);
                ser_data <= head(sr);
`ifndef OUT_SER_PARITY_EN
                ser_done <= (cnt == LAST_M1);
`endif
`ifdef OUT_SER_PARITY_EN
            end else if (to_par) begin
                ser_data <= par_bit;
                ser_done <= 1'b1;
`endif
            end else if (state_nxt == IDLE) begin
                ser_data <= IDLE_LEVEL;
                ser_sel  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/out_ser.md
Name: out_ser

Overview:
- Parallel-to-serial output stage that sits directly upstream of the IOB output register.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock on ser_data.
- Drives ser_sel as the downstream register's bypass select: 1 while bits stream, so they pass through; 0 when idle, so the register holds its last captured value.
- Optional parity bit follows each word.

Parameters:
- WIDTH, 8: serialized word width in bits, legal range 2..32.
- LSB_FIRST, 1: 1 shifts bit 0 out first; 0 shifts bit WIDTH-1 out first.
- IDLE_LEVEL, 1'b1: value driven on ser_data when no bit is being sent.

Ports:
- clk  input  1  clock, rising edge; clkbuf_sink.
- rst_n  input  1  asynchronous active-low reset.
- par_data  input  WIDTH  parallel word to serialize.
- par_valid  input  1  par_data valid.
- par_ready  output  1  block accepts par_data this cycle.
- ser_data  output  1  serial bit; feeds the downstream dataIn.
- ser_sel  output  1  1 while a bit is presented; feeds the downstream sel.
- ser_done  output  1  one-cycle pulse on the final bit of a word (parity bit when enabled).
- busy  output  1  state != IDLE.

Behaviour:
- Reset: asynchronous on rst_n low, with synchronous deassertion assumed upstream.
  - During reset: state=IDLE, shift register=0, bit counter=0, ser_data=IDLE_LEVEL, ser_sel=0, ser_done=0, busy=0, par_ready=0.
  - par_ready is held low while rst_n is low and rises combinationally from IDLE after release.
- All outputs except par_ready are registered. par_ready is combinational from state and counter.
- Accept: a word is accepted on a rising edge with par_valid && par_ready. On that edge:
  - par_data is loaded into the shift register and the counter is cleared.
  - The first bit appears on ser_data with ser_sel=1 in the cycle immediately after acceptance (latency 1).
- States:
  - IDLE: par_ready=1. On accept go to SHIFT; otherwise hold IDLE_LEVEL with ser_sel=0.
  - SHIFT: presents one bit per cycle and the counter counts 0..WIDTH-1. Bit order follows LSB_FIRST.
  - SHIFT on the cycle where the counter reaches WIDTH-1 (last data bit presented):
    - Without parity: par_ready=1 and ser_done=1.
    - If accepted, the next cycle shows bit 0 of the new word. This gives back-to-back streaming with no gap and no IDLE_LEVEL cycle.
    - If not accepted, go to IDLE.
  - PARITY (only when the feature is compiled in): see Optional Feature.
- par_ready is 0 at all other SHIFT counts. par_valid during those cycles is ignored, and par_data must be held by the producer.
- The counter is clog2(WIDTH+1) bits wide, clears on load, and never wraps past WIDTH-1 within a word.
- ser_sel=1 exactly during cycles in which a data or parity bit is on ser_data; otherwise 0.
- rst_n asserted mid-word aborts the word immediately: outputs go to their reset values and the partial word is discarded, with no ser_done.
- par_valid held with unchanged data after acceptance counts as a new word whenever par_ready is high.

Optional Feature:
- Macro: OUT_SER_PARITY_EN.
- Defined:
  - A PARITY state follows the last data bit and presents the even-parity bit, XOR of all WIDTH accepted bits, with ser_sel=1.
  - ser_done pulses in PARITY instead of on the last data bit.
  - par_ready is 0 on the last data bit and 1 in PARITY, so back-to-back acceptance happens from PARITY.
  - Frame length is WIDTH+1 cycles.
- Undefined: no PARITY state, no parity logic; frame length is WIDTH cycles.

Test Plan:
- Reset and idle: rst_n=0 for 3 cycles, then release with par_valid=0 for 5 cycles -> ser_data=1, ser_sel=0, busy=0, ser_done=0 throughout; par_ready=0 during reset, 1 after release.
- Single word: WIDTH=8, LSB_FIRST=1, accept 8'hA5 -> ser_data 1,0,1,0,0,1,0,1 on cycles +1..+8.
  - ser_sel=1 on exactly those 8 cycles; ser_done on cycle +8; idle level from +9.
- MSB-first: LSB_FIRST=0, accept 8'h81 -> 1,0,0,0,0,0,0,1; then ser_sel drops.
- Back-to-back: par_valid held high with 8'hFF then 8'h00 -> 16 consecutive ser_sel=1 cycles, 8 ones then 8 zeros, ser_done pulses at cycles +8 and +16, no idle gap.
- Parity (OUT_SER_PARITY_EN): accept 8'h07 -> 8 data bits, then parity bit 1 on cycle +9 with ser_done there. 8'h03 -> parity 0.
- Reset mid-word: accept 8'hF0, assert rst_n=0 after 3 bits -> outputs return to reset values in the same cycle with no ser_done.
  - After release, accept 8'h0F -> clean frame 1,1,1,1,0,0,0,0.
